cache_arbiter: RTL and testbench

CACHE_ARBITER -- requirements
Module: cache_arbiter

---
 rtl/rv32i_types.sv | 16 +
 rtl/cache_arbiter.sv | 91 +++++++++
 tb/tb_cache_arbiter.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/rv32i_types.sv
// rv32i_types: shared control types for the rv32i core, including the cache arbiter FSM state and grant encoding
package rv32i_types;

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D,
    RESP
  } arb_state_t;

  typedef enum logic {
    GRANT_I,
    GRANT_D
  } grant_t;

endpackage

// File: rtl/cache_arbiter.sv
// cache_arbiter: round-robin arbiter sharing one physical memory port between icache fills and dcache fills/writebacks
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   i_read/i_address -> i_rdata/i_resp          icache line-fill request and response
//   d_read/d_write/d_address/d_wdata -> d_rdata/d_resp  dcache fill/writeback request and response
//   pmem_read/pmem_write/pmem_address/pmem_wdata <- pmem_rdata/pmem_resp  physical memory port
module cache_arbiter
  import rv32i_types::*;
#(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  arb_state_t        state, state_n;
  grant_t            last_grant;
  logic              op_w;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q, line_q;
  logic              d_req, pick_i, serving;

  assign d_req   = d_read | d_write;
  // icache wins unless the dcache is also asking and the icache was served last
  assign pick_i  = i_read & (~d_req | (last_grant == GRANT_D));
  assign serving = (state == SERVE_I) || (state == SERVE_D);

  always_comb begin
    state_n = state == IDLE ? (pick_i ? SERVE_I : d_req ? SERVE_D : IDLE)
            : state == RESP ? IDLE
            : pmem_resp     ? RESP : state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // last_grant is updated on pmem_resp, so in RESP it names the requester just served
  always_comb begin
    pmem_read  = serving & ~op_w;
    pmem_write = serving & op_w;
    i_resp     = (state == RESP) && (last_grant == GRANT_I);
    d_resp     = (state == RESP) && (last_grant == GRANT_D);
  end

  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;
  assign i_rdata      = line_q;
  assign d_rdata      = line_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= GRANT_D;
      op_w       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      line_q     <= '0;
    end else if (state == IDLE) begin
      if (pick_i) begin
        addr_q <= i_address;
        op_w   <= 1'b0;
      end else if (d_req) begin
        addr_q  <= d_address;
        wdata_q <= d_wdata;
        op_w    <= d_write;
      end
    end else if (serving && pmem_resp) begin
      line_q     <= pmem_rdata;
      last_grant <= state == SERVE_I ? GRANT_I : GRANT_D;
    end
  end

endmodule

// File: tb/tb_cache_arbiter.sv
// tb_cache_arbiter: directed scoreboard bench for cache_arbiter with a behavioural physical memory responder
module tb_cache_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         i_read, d_read, d_write, pmem_resp;
  logic [31:0]  i_address, d_address;
  logic [255:0] d_wdata, pmem_rdata;
  logic [255:0] i_rdata, d_rdata, pmem_wdata;
  logic         i_resp, d_resp, pmem_read, pmem_write;
  logic [31:0]  pmem_address;

  typedef struct {
    bit           is_i;
    bit           wr;
    logic [31:0]  addr;
    logic [255:0] wdata;
    logic [255:0] rdata;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  cache_arbiter #(.ADDR_W(32), .LINE_W(256)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_strobes"}, {pmem_read, pmem_write}, 0);
    chk({tag, "_resps"}, {i_resp, d_resp}, 0);
  endtask

  task automatic push(input bit is_i, input bit wr, input logic [31:0] addr,
                      input logic [255:0] wdata, input logic [255:0] rdata);
    exp_t e;
    e.is_i = is_i; e.wr = wr; e.addr = addr; e.wdata = wdata; e.rdata = rdata;
    q.push_back(e);
  endtask

  // Waits for the next strobe, holds it for `hold` cycles, answers, then checks the response pulse.
  task automatic serve(input int hold, input bit perturb, input bit keep);
    exp_t e;
    bit   seen = 0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clk);
      seen = pmem_read | pmem_write;
    end
    chk("strobe_seen", seen, 1);
    if (!seen || q.size() == 0) return;
    e = q.pop_front();
    for (int t = 1; t <= hold; t++) begin
      if (t > 1) @(negedge clk);
      chk("pmem_read", pmem_read, !e.wr);
      chk("pmem_write", pmem_write, e.wr);
      chk("pmem_address", pmem_address, e.addr);
      if (e.wr) chk("pmem_wdata", pmem_wdata, e.wdata);
      chk("resp_busy", {i_resp, d_resp}, 0);
      if (perturb) begin
        i_address = $urandom;
        d_address = $urandom;
        d_wdata   = {8{$urandom}};
      end
      if (t == hold) begin
        pmem_resp  = 1'b1;
        pmem_rdata = e.rdata;
      end
    end
    @(negedge clk);
    pmem_resp  = 1'b0;
    pmem_rdata = {8{32'hDEAD_BEEF}};
    chk("resp_strobes", {pmem_read, pmem_write}, 0);
    chk("i_resp", i_resp, e.is_i);
    chk("d_resp", d_resp, !e.is_i);
    chk("rdata", e.is_i ? i_rdata : d_rdata, e.rdata);
    if (!keep) begin
      if (e.is_i) i_read = 1'b0;
      else begin
        d_read  = 1'b0;
        d_write = 1'b0;
      end
    end
    @(negedge clk);
    chk("after_resp", {i_resp, d_resp}, 0);
  endtask

  initial begin
    bit seen;
    rst_n = 1'b0; i_read = 0; d_read = 0; d_write = 0; pmem_resp = 0;
    i_address = '0; d_address = '0; d_wdata = '0; pmem_rdata = '0;
    #3;
    chk("rst_outputs", {pmem_read, pmem_write, i_resp, d_resp}, 0);
    chk("rst_addr", pmem_address, 0);
    chk("rst_wdata", pmem_wdata, 0);
    chk("rst_rdata", i_rdata | d_rdata, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // spurious pmem_resp while idle
    @(negedge clk);
    pmem_resp = 1'b1;
    @(negedge clk);
    chk_quiet("spurious1");
    pmem_resp = 1'b0;
    @(negedge clk);
    chk_quiet("spurious2");

    // icache only fill
    push(1, 0, 32'h40, '0, {32{8'hA5}});
    i_read = 1; i_address = 32'h40;
    serve(4, 0, 0);

    // dcache writeback with inputs scrambled mid-transaction
    push(0, 1, 32'h1000, {8{32'h1234_5678}}, {8{32'h0BAD_F00D}});
    d_write = 1; d_address = 32'h1000; d_wdata = {8{32'h1234_5678}};
    serve(3, 1, 0);

    // dcache fill
    push(0, 0, 32'h2040, '0, {8{32'hCAFE_0001}});
    d_read = 1; d_address = 32'h2040;
    serve(2, 0, 0);

    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // tie from reset: icache first; icache kept requesting makes a second tie, dcache wins it
    push(1, 0, 32'h3000, '0, {8{32'h1111_0000}});
    push(0, 0, 32'h4000, '0, {8{32'h2222_0000}});
    push(1, 0, 32'h3000, '0, {8{32'h3333_0000}});
    i_read = 1; i_address = 32'h3000;
    d_read = 1; d_address = 32'h4000;
    serve(2, 0, 1);
    serve(2, 0, 0);
    serve(1, 0, 0);

    // read and write together count as a write
    push(0, 1, 32'h5000, {8{32'h5555_AAAA}}, {8{32'h7777_0000}});
    d_read = 1; d_write = 1; d_address = 32'h5000; d_wdata = {8{32'h5555_AAAA}};
    serve(3, 0, 0);

    // reset mid-transaction abandons it
    i_read = 1; i_address = 32'h80;
    seen = 0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clk);
      seen = pmem_read;
    end
    chk("abort_strobe_seen", seen, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_outputs", {pmem_read, pmem_write, i_resp, d_resp}, 0);
    chk("abort_addr", pmem_address, 0);
    chk("abort_wdata", pmem_wdata, 0);
    chk("abort_rdata", i_rdata | d_rdata, 0);
    i_read = 0;
    pmem_resp = 1;
    repeat (3) begin
      @(negedge clk);
      chk_quiet("abort_hold");
    end
    pmem_resp = 0;
    rst_n = 1'b1;

    push(1, 0, 32'h200, '0, {8{32'h9999_4242}});
    i_read = 1; i_address = 32'h200;
    serve(1, 0, 0);
    @(negedge clk);
    chk_quiet("final_idle");
    chk("queue_drained", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
